// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer slice.
//   UART_DATA_W   width of one received byte
//   UART_ENTRY_W  FIFO entry width: {parity_tag, byte}
//   rx_state_e    receive handshake FSM states
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_ENTRY_W = UART_DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CLEAR   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// The head entry is presented on rd_data whenever the FIFO is not empty;
// rd_data reads as zero while empty so it never shows stale or unknown data.
// A write and a pop in the same cycle are both honoured when full (the pop
// frees the slot). A pop on an empty FIFO is ignored, including one that
// coincides with a write.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   wr_en, wr_data      push request and entry
//   rd_en               pop the head entry
//   rd_data             head entry (FWFT)
//   empty, full, count  occupancy status, count is 0..DEPTH
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: synchronises the receiver's byte-ready flag, runs a
// capture/clear handshake with the receiver and queues each byte with its
// parity tag in a FWFT FIFO for the processor side.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the synchronised rx flag
// CAPTURE | one cycle: push {parity, byte} or drop it and flag overrun
// CLEAR   | clr_rx_flag_out held high until the rx flag is seen low
//
// Build option UART_RX_BUFFER_PARITY_DROP_EN: bytes with a parity error are
// discarded and counted in parity_drop_cnt (saturating); rd_parity_err is 0.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   rx_data_in, rx_flag_in,
//   rx_parity_in                     receiver byte, ready flag, parity error
//   clr_rx_flag_out                  clear request to the receiver
//   rd_en, rd_data, rd_parity_err    processor-side FWFT read port
//   empty, full, count               FIFO occupancy
//   overrun, overrun_clr             sticky drop indicator and its clear
//   parity_drop_cnt                  (option only) dropped-parity byte count
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [UART_DATA_W-1:0]  rx_data_in,
    input  logic                    rx_flag_in,
    input  logic                    rx_parity_in,
    output logic                    clr_rx_flag_out,
    input  logic                    rd_en,
    output logic [UART_DATA_W-1:0]  rd_data,
    output logic                    rd_parity_err,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
`ifdef UART_RX_BUFFER_PARITY_DROP_EN
    output logic [7:0]              parity_drop_cnt,
`endif
    output logic                    overrun,
    input  logic                    overrun_clr
);

    logic [SYNC_STAGES-1:0]  flag_sync;
    logic [SYNC_STAGES-1:0]  par_sync;
    logic                    flag_s;
    logic                    par_s;

    rx_state_e               state;
    rx_state_e               state_nxt;

    logic                    capture;
    logic                    par_drop;
    logic                    fifo_wr;
    logic                    ovr_set;
    logic [UART_ENTRY_W-1:0] fifo_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_sync <= '0;
            par_sync  <= '0;
        end else begin
            flag_sync <= {flag_sync[SYNC_STAGES-2:0], rx_flag_in};
            par_sync  <= {par_sync[SYNC_STAGES-2:0], rx_parity_in};
        end
    end

    assign flag_s = flag_sync[SYNC_STAGES-1];
    assign par_s  = par_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        clr_rx_flag_out = 1'b0;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (flag_s) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_rx_flag_out = 1'b1;
                if (!flag_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_BUFFER_PARITY_DROP_EN
    assign par_drop = capture && par_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_drop_cnt <= '0;
        end else if (par_drop && (parity_drop_cnt != 8'hFF)) begin
            parity_drop_cnt <= parity_drop_cnt + 8'd1;
        end
    end

    assign rd_parity_err = 1'b0;
`else
    assign par_drop      = 1'b0;
    assign rd_parity_err = fifo_rd_data[UART_DATA_W];
`endif

    // A pop in the capture cycle frees a slot, so a full FIFO still accepts.
    assign fifo_wr = capture && !par_drop && (!full || rd_en);
    assign ovr_set = capture && !par_drop && full && !rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data ({par_s, rx_data_in}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign rd_data = fifo_rd_data[UART_DATA_W-1:0];

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data_in;
    logic       rx_flag_in;
    logic       rx_parity_in;
    logic       clr_rx_flag_out;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       overrun_clr;
`ifdef UART_RX_BUFFER_PARITY_DROP_EN
    logic [7:0] parity_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_buffer #(
        .DEPTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data_in      (rx_data_in),
        .rx_flag_in      (rx_flag_in),
        .rx_parity_in    (rx_parity_in),
        .clr_rx_flag_out (clr_rx_flag_out),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_parity_err   (rd_parity_err),
        .empty           (empty),
        .full            (full),
        .count           (count),
`ifdef UART_RX_BUFFER_PARITY_DROP_EN
        .parity_drop_cnt (parity_drop_cnt),
`endif
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one byte through the full handshake; every wait is bounded.
    task automatic send_byte(input logic [7:0] d, input logic p);
        int n;
        rx_data_in   = d;
        rx_parity_in = p;
        rx_flag_in   = 1'b1;
        n = 0;
        while (!clr_rx_flag_out && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("hs_clr_rise", {31'd0, clr_rx_flag_out}, 32'd1);
        rx_flag_in = 1'b0;
        n = 0;
        while (clr_rx_flag_out && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("hs_clr_fall", {31'd0, clr_rx_flag_out}, 32'd0);
        rx_parity_in = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        rx_data_in   = 8'h00;
        rx_flag_in   = 1'b0;
        rx_parity_in = 1'b0;
        rd_en        = 1'b0;
        overrun_clr  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_clr",     {31'd0, clr_rx_flag_out}, 32'd0);
        check("rst_empty",   {31'd0, empty},           32'd1);
        check("rst_full",    {31'd0, full},            32'd0);
        check("rst_count",   {27'd0, count},           32'd0);
        check("rst_overrun", {31'd0, overrun},         32'd0);
        check("rst_rd_data", {24'd0, rd_data},         32'd0);
        check("rst_rd_par",  {31'd0, rd_parity_err},   32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: single byte, exact latency: write lands at edge SYNC_STAGES+2
        rx_data_in   = 8'hA5;
        rx_parity_in = 1'b0;
        rx_flag_in   = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_empty_pre", {31'd0, empty}, 32'd1);
        @(negedge clk);
        check("t1_clr",     {31'd0, clr_rx_flag_out}, 32'd1);
        check("t1_empty",   {31'd0, empty},           32'd0);
        check("t1_rd_data", {24'd0, rd_data},         32'h A5);
        check("t1_count",   {27'd0, count},           32'd1);
        rx_flag_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_clr_fall", {31'd0, clr_rx_flag_out}, 32'd0);
        check("t1_count_hold", {27'd0, count}, 32'd1);
        pop();
        check("t1_empty_after_pop", {31'd0, empty}, 32'd1);

        // 2: fill, overrun, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        check("t2_full",  {31'd0, full},   32'd1);
        check("t2_count", {27'd0, count},  32'd16);
        check("t2_ovr_pre", {31'd0, overrun}, 32'd0);
        send_byte(8'hFF, 1'b0);
        check("t2_overrun", {31'd0, overrun}, 32'd1);
        check("t2_count_after_drop", {27'd0, count}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("t2_drain", {24'd0, rd_data}, 32'(i));
            pop();
        end
        check("t2_empty", {31'd0, empty}, 32'd1);
        check("t2_ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t2_ovr_clr", {31'd0, overrun}, 32'd0);

        // 3: pop during CAPTURE while full -> accepted, no overrun
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
        check("t3_full", {31'd0, full}, 32'd1);
        rx_data_in = 8'h3C;
        rx_flag_in = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t3_overrun", {31'd0, overrun},         32'd0);
        check("t3_count",   {27'd0, count},           32'd16);
        check("t3_clr",     {31'd0, clr_rx_flag_out}, 32'd1);
        check("t3_head",    {24'd0, rd_data},         32'h11);
        rx_flag_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_clr_fall", {31'd0, clr_rx_flag_out}, 32'd0);
        for (int i = 0; i < 15; i++) pop();
        check("t3_tail", {24'd0, rd_data}, 32'h3C);
        check("t3_count_tail", {27'd0, count}, 32'd1);
        pop();
        check("t3_empty", {31'd0, empty}, 32'd1);

        // 4: parity-tagged byte
        send_byte(8'h5A, 1'b1);
`ifdef UART_RX_BUFFER_PARITY_DROP_EN
        check("t4_empty",    {31'd0, empty},     32'd1);
        check("t4_drop_cnt", {24'd0, parity_drop_cnt}, 32'd1);
`else
        check("t4_rd_data", {24'd0, rd_data},       32'h5A);
        check("t4_rd_par",  {31'd0, rd_parity_err}, 32'd1);
        pop();
        check("t4_empty", {31'd0, empty}, 32'd1);
`endif
        send_byte(8'h6B, 1'b0);
        check("t4_clean_par", {31'd0, rd_parity_err}, 32'd0);
        check("t4_clean_data", {24'd0, rd_data}, 32'h6B);
        pop();

        // 5: reset during CLEAR with the flag still high
        rx_data_in = 8'h77;
        rx_flag_in = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_in_clear", {31'd0, clr_rx_flag_out}, 32'd1);
        check("t5_count_pre", {27'd0, count}, 32'd1);
        reset = 1'b0;
        #1;
        check("t5_clr_async", {31'd0, clr_rx_flag_out}, 32'd0);
        check("t5_count_rst", {27'd0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_recapture_clr", {31'd0, clr_rx_flag_out}, 32'd1);
        check("t5_count",   {27'd0, count},   32'd1);
        check("t5_rd_data", {24'd0, rd_data}, 32'h77);
        rx_flag_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_clr_fall", {31'd0, clr_rx_flag_out}, 32'd0);
        pop();
        check("t5_empty", {31'd0, empty}, 32'd1);

        // 6: reads on empty, then set/clear collision on overrun
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        check("t6_count", {27'd0, count}, 32'd0);
        check("t6_empty", {31'd0, empty}, 32'd1);
        check("t6_rd_x",  {31'd0, $isunknown(rd_data)}, 32'd0);
        send_byte(8'hC3, 1'b0);
        check("t6_ptr_data",  {24'd0, rd_data}, 32'hC3);
        check("t6_ptr_count", {27'd0, count},   32'd1);
        for (int i = 1; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0);
        check("t6_full", {31'd0, full}, 32'd1);
        check("t6_ovr_pre", {31'd0, overrun}, 32'd0);
        rx_data_in = 8'hEE;
        rx_flag_in = 1'b1;
        repeat (3) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t6_set_wins", {31'd0, overrun}, 32'd1);
        check("t6_head", {24'd0, rd_data}, 32'hC3);
        rx_flag_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_clr_fall", {31'd0, clr_rx_flag_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
